// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner: column scan, tick-based debounce,
// one hex code per press on a valid/ready handshake, plus a 32-bit entry word.
module keypad_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  row_i,
    output logic [3:0]  col_o,
    output logic        key_valid_o,
    output logic [3:0]  key_code_o,
    input  logic        key_ready_i,
    output logic [31:0] word_o,
    output logic        overflow_o,
    input  logic        clear_i
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    // Lowest-index low row wins when several rows are pulled down.
    function automatic logic [1:0] win_row(input logic [3:0] rows);
        logic [1:0] r;
        if (!rows[0])      r = 2'd0;
        else if (!rows[1]) r = 2'd1;
        else if (!rows[2]) r = 2'd2;
        else               r = 2'd3;
        return r;
    endfunction

    logic [3:0]    row_p0;
    logic [3:0]    row_p1;
    logic [TW-1:0] tick_cnt;
    logic          tick;

    state_t        state;
    state_t        state_n;
    logic [1:0]    col_idx;
    logic [1:0]    col_idx_n;
    logic [1:0]    lat_row;
    logic [1:0]    lat_row_n;
    logic [CW-1:0] debcnt;
    logic [CW-1:0] debcnt_n;
    logic [CW-1:0] relcnt;
    logic [CW-1:0] relcnt_n;
    logic          accept;
    logic          any_low;
    logic [1:0]    cur_row;
    logic [3:0]    code_new;
    logic          xfer_block;

    // Stage p0/p1: two-flop synchroniser on the asynchronous row inputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_p0 <= 4'hF;
            row_p1 <= 4'hF;
        end else begin
            row_p0 <= row_i;
            row_p1 <= row_p0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign tick    = (tick_cnt == TICK_LAST);
    assign any_low = (row_p1 != 4'hF);
    assign cur_row = win_row(row_p1);
    assign col_o   = ~(4'b0001 << col_idx);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= SCAN;
            col_idx <= 2'd0;
            lat_row <= 2'd0;
            debcnt  <= '0;
            relcnt  <= '0;
        end else begin
            state   <= state_n;
            col_idx <= col_idx_n;
            lat_row <= lat_row_n;
            debcnt  <= debcnt_n;
            relcnt  <= relcnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        col_idx_n = col_idx;
        lat_row_n = lat_row;
        debcnt_n  = debcnt;
        relcnt_n  = relcnt;
        accept    = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (!any_low) begin
                        col_idx_n = col_idx + 2'd1;
                    end else begin
                        lat_row_n = cur_row;
                        debcnt_n  = CW'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            accept   = 1'b1;
                            relcnt_n = '0;
                            state_n  = PRESSED;
                        end else begin
                            state_n = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (any_low && (cur_row == lat_row)) begin
                        debcnt_n = debcnt + CW'(1);
                        if (debcnt + CW'(1) == CNT_LAST) begin
                            accept   = 1'b1;
                            relcnt_n = '0;
                            state_n  = PRESSED;
                        end
                    end else begin
                        debcnt_n  = '0;
                        col_idx_n = col_idx + 2'd1;
                        state_n   = SCAN;
                    end
                end
                PRESSED: begin
                    // Column stays parked on the key until a clean release.
                    if (any_low) begin
                        relcnt_n = '0;
                    end else if (relcnt + CW'(1) == CNT_LAST) begin
                        relcnt_n  = '0;
                        col_idx_n = col_idx + 2'd1;
                        state_n   = SCAN;
                    end else begin
                        relcnt_n = relcnt + CW'(1);
                    end
                end
                default: begin
                    state_n = SCAN;
                end
            endcase
        end
    end

    assign code_new   = {lat_row_n, col_idx};
    assign xfer_block = key_valid_o && !key_ready_i;

    // Handshake: a pending code is never overwritten unless it transfers now.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_valid_o <= 1'b0;
            key_code_o  <= 4'h0;
        end else if (accept && !xfer_block) begin
            key_valid_o <= 1'b1;
            key_code_o  <= code_new;
        end else if (key_ready_i) begin
            key_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_o     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (clear_i) begin
                word_o <= accept ? {28'h0, code_new} : 32'h0;
            end else if (accept) begin
                word_o <= {word_o[27:0], code_new};
            end
            overflow_o <= (overflow_o & ~clear_i) | (accept & xfer_block);
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a key-matrix model drives rows from the column
// strobe; emitted codes and the entry word are compared with expectations.
module tb_keypad_scan;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row_i;
    logic [3:0]  col_o;
    logic        key_valid_o;
    logic [3:0]  key_code_o;
    logic        key_ready_i = 1'b0;
    logic [31:0] word_o;
    logic        overflow_o;
    logic        clear_i = 1'b0;

    logic [15:0] keys = 16'h0;
    logic [3:0]  got[$];
    logic [3:0]  exp_q[$];
    logic [31:0] word_exp;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  code;
    } vec_t;
    vec_t tbl[6];

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .row_i       (row_i),
        .col_o       (col_o),
        .key_valid_o (key_valid_o),
        .key_code_o  (key_code_o),
        .key_ready_i (key_ready_i),
        .word_o      (word_o),
        .overflow_o  (overflow_o),
        .clear_i     (clear_i)
    );

    always #5 clock = ~clock;

    // Key k sits at row k/4, column k%4 and shorts that row to a driven-low column.
    always_comb begin
        row_i = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (keys[k] && !col_o[k % 4]) row_i[k / 4] = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (reset && key_valid_o && key_ready_i) got.push_back(key_code_o);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic press(input logic [15:0] m, input int hold, input int rel);
        keys = m;
        step(hold);
        keys = 16'h0;
        step(rel);
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
    endtask

    // Waits for the column strobe to newly arrive at c (leave it first, then reach it).
    task automatic wait_col_arrive(input logic [3:0] c, input string name);
        int n;
        n = 0;
        while (col_o == c && n < 40) begin
            step(1);
            n++;
        end
        n = 0;
        while (col_o != c && n < 40) begin
            step(1);
            n++;
        end
        check(name, {28'h0, col_o}, {28'h0, c});
    endtask

    // Same-column key set: the lowest row, i.e. the lowest key index, wins.
    function automatic logic [3:0] model_code(input logic [15:0] m);
        for (int k = 0; k < 16; k++) begin
            if (m[k]) return 4'(k);
        end
        return 4'h0;
    endfunction

    initial begin
        logic [3:0] col_exp;
        int n;

        tbl[0] = '{16'h0200, 4'h9};
        tbl[1] = '{16'h0001, 4'h0};
        tbl[2] = '{16'h8000, 4'hF};
        tbl[3] = '{16'h2200, 4'h9};
        tbl[4] = '{16'h8888, 4'h3};
        tbl[5] = '{16'h1010, 4'h4};

        // Reset and idle column rotation
        step(3);
        check("rst_col", {28'h0, col_o}, 32'he);
        check("rst_valid", {31'h0, key_valid_o}, 32'h0);
        check("rst_code", {28'h0, key_code_o}, 32'h0);
        check("rst_word", word_o, 32'h0);
        check("rst_ovf", {31'h0, overflow_o}, 32'h0);
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            col_exp = ~(4'b0001 << ((k / 4) % 4));
            check("idle_col", {28'h0, col_o}, {28'h0, col_exp});
            check("idle_valid", {31'h0, key_valid_o}, 32'h0);
        end
        check("idle_word", word_o, 32'h0);

        // Table of single presses with ready held high
        key_ready_i = 1'b1;
        pulse_clear();
        word_exp = 32'h0;
        check("clr_word", word_o, word_exp);
        for (int i = 0; i < 6; i++) begin
            got.delete();
            press(tbl[i].keys, 50, 40);
            word_exp = {word_exp[27:0], tbl[i].code};
            check("tbl_count", 32'(got.size()), 32'h1);
            if (got.size() >= 1) check("tbl_code", {28'h0, got[0]}, {28'h0, tbl[i].code});
            check("tbl_word", word_o, word_exp);
        end

        // Long hold then release: one code, column parked until clean release
        got.delete();
        keys = 16'h0200;
        n = 0;
        while (got.size() == 0 && n < 80) begin
            step(1);
            n++;
        end
        check("hold_accept", 32'(got.size()), 32'h1);
        step(40);
        check("hold_col", {28'h0, col_o}, 32'hd);
        keys = 16'h0;
        step(4);
        check("rel_col_held", {28'h0, col_o}, 32'hd);
        n = 0;
        while (col_o == 4'b1101 && n < 20) begin
            step(1);
            n++;
        end
        check("rel_col_next", {28'h0, col_o}, 32'hb);
        check("hold_single", 32'(got.size()), 32'h1);
        word_exp = {word_exp[27:0], 4'h9};
        check("hold_word", word_o, word_exp);

        // Bounce: row 0 low at column 3 for a single tick
        got.delete();
        wait_col_arrive(4'b0111, "bnc_find");
        keys = 16'h0008;
        step(4);
        check("bnc_col_held", {28'h0, col_o}, 32'h7);
        keys = 16'h0;
        step(4);
        check("bnc_col_next", {28'h0, col_o}, 32'he);
        step(20);
        check("bnc_none", 32'(got.size()), 32'h0);
        check("bnc_valid", {31'h0, key_valid_o}, 32'h0);
        check("bnc_word", word_o, word_exp);

        // Backpressure and overflow, then clear leaves the handshake alone
        key_ready_i = 1'b0;
        got.delete();
        pulse_clear();
        press(16'h0008, 50, 40);
        press(16'h0020, 50, 40);
        check("bp_valid", {31'h0, key_valid_o}, 32'h1);
        check("bp_code", {28'h0, key_code_o}, 32'h3);
        check("bp_ovf", {31'h0, overflow_o}, 32'h1);
        check("bp_word", word_o, 32'h35);
        pulse_clear();
        check("clr2_word", word_o, 32'h0);
        check("clr2_ovf", {31'h0, overflow_o}, 32'h0);
        check("clr2_valid", {31'h0, key_valid_o}, 32'h1);
        check("clr2_code", {28'h0, key_code_o}, 32'h3);
        key_ready_i = 1'b1;
        step(1);
        key_ready_i = 1'b0;
        check("bp_drop", {31'h0, key_valid_o}, 32'h0);
        check("bp_count", 32'(got.size()), 32'h1);
        if (got.size() >= 1) check("bp_xfer_code", {28'h0, got[0]}, 32'h3);
        key_ready_i = 1'b1;

        // Entry of digits 1..9
        pulse_clear();
        got.delete();
        for (int d = 1; d <= 9; d++) press(16'h0001 << d, 50, 40);
        check("entry_word", word_o, 32'h23456789);
        check("entry_count", 32'(got.size()), 32'h9);
        for (int i = 0; i < 9 && i < got.size(); i++) begin
            check("entry_code", {28'h0, got[i]}, 32'(i + 1));
        end
        check("entry_ovf", {31'h0, overflow_o}, 32'h0);

        // Asynchronous reset during debounce
        wait_col_arrive(4'b1101, "ard_find");
        keys = 16'h0002;
        step(5);
        #2;
        reset = 1'b0;
        #1;
        check("ard_col", {28'h0, col_o}, 32'he);
        check("ard_valid", {31'h0, key_valid_o}, 32'h0);
        check("ard_code", {28'h0, key_code_o}, 32'h0);
        check("ard_word", word_o, 32'h0);
        check("ard_ovf", {31'h0, overflow_o}, 32'h0);
        keys = 16'h0;
        step(2);
        reset = 1'b1;
        got.delete();
        step(40);
        check("ard_none", 32'(got.size()), 32'h0);
        check("ard_valid2", {31'h0, key_valid_o}, 32'h0);
        check("ard_word2", word_o, 32'h0);

        // Randomized presses with random consumer ready
        word_exp = 32'h0;
        exp_q.delete();
        got.delete();
        for (int p = 0; p < 12; p++) begin
            int c;
            int rm;
            int hold;
            int rel;
            logic [15:0] m;
            c = $urandom_range(0, 3);
            rm = $urandom_range(1, 15);
            m = 16'h0;
            for (int r = 0; r < 4; r++) begin
                if (rm[r]) m[r * 4 + c] = 1'b1;
            end
            hold = $urandom_range(40, 70);
            rel = $urandom_range(30, 50);
            for (int t = 0; t < hold + rel; t++) begin
                keys = (t < hold) ? m : 16'h0;
                key_ready_i = 1'($urandom_range(0, 1));
                step(1);
            end
            exp_q.push_back(model_code(m));
            word_exp = {word_exp[27:0], model_code(m)};
            check("rnd_word", word_o, word_exp);
        end
        key_ready_i = 1'b1;
        step(10);
        check("rnd_count", 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check("rnd_code", {28'h0, got[i]}, {28'h0, exp_q[i]});
        end
        check("rnd_ovf", {31'h0, overflow_o}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Input-side counterpart to the 8-digit seven-segment display path: scans a 4x4 active-low matrix keypad, debounces it, and emits one 4-bit hex key code per press over a valid/ready handshake.
- Also shifts each accepted code into a 32-bit entry word that the display path can show (8 hex digits) and that the datapath can read as operand or address input.

Parameters:
- SCAN_DIV, 50000: clock cycles per scan tick; the column is held and rows settle for this long before sampling; minimum 2.
- DEBOUNCE_CNT, 4: consecutive identical tick samples required to accept a press or a release; minimum 1.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- row_i  input  4  keypad rows, active-low (board pull-ups); synchronised internally through 2 flops.
- col_o  output 4  keypad column drive, active-low, exactly one bit low at any time.
- key_valid_o  output 1  a key code is pending.
- key_code_o  output 4  pending code = row*4 + col (0..15).
- key_ready_i  input  1  consumer accepts; transfer occurs when valid && ready.
- word_o  output 32  entry word; the newest digit is in [3:0].
- overflow_o  output 1  sticky; a press was detected while a code was still pending.
- clear_i  input  1  synchronous; zeroes word_o and overflow_o.

Behaviour:
- Reset (async assert, sync to clock on release): col_o=4'b1110 (col 0), key_valid_o=0, key_code_o=0, word_o=0, overflow_o=0, FSM=SCAN, tick counter=0, debounce counter=0.
- Tick: a free-running counter 0..SCAN_DIV-1 pulses `tick` for one cycle at terminal count. All row sampling happens only on tick, using the synchronised rows.
- Row select: if several rows are low, the lowest index wins. A press is any synchronised row bit = 0.
- FSM states and transitions:
  - SCAN: on tick with no row low, rotate col_o to the next column (col 3 wraps to col 0). On tick with a row low, latch row/col, set debcnt=1, and go to DEBOUNCE without rotating the column.
  - DEBOUNCE: on each tick, if the same single winning row is still low, increment debcnt. Otherwise (changed row or no press), go to SCAN and rotate col_o. When debcnt reaches DEBOUNCE_CNT, the press is accepted: go to PRESSED. If DEBOUNCE_CNT=1, acceptance happens on the SCAN tick itself.
  - PRESSED: column held. Each tick with all rows high increments relcnt; a tick with any row low clears relcnt. When relcnt reaches DEBOUNCE_CNT, go to SCAN, rotate the column, and clear relcnt. Keys held for any length produce exactly one code.
- Acceptance effects (the cycle after the accepting tick):
  - word_o <= {word_o[27:0], code}. This happens regardless of the handshake.
  - If key_valid_o=0: key_valid_o<=1 and key_code_o<=code.
  - If key_valid_o=1 and no transfer is happening this cycle: the new code is dropped from the handshake (the pending code is kept), and overflow_o<=1.
  - If key_valid_o=1 and a transfer happens this same cycle: the new code is loaded and valid stays 1; no overflow.
- Handshake: key_valid_o stays asserted and key_code_o is stable until a cycle with key_ready_i=1. After that cycle, valid drops (unless reloaded as above). key_ready_i while valid=0 has no effect.
- clear_i: word_o<=0 and overflow_o<=0 in the next cycle. It does not affect the FSM or the pending handshake. clear_i together with an acceptance gives word_o = {28'b0, code}.
- Reset mid-debounce or mid-handshake: all state is discarded and nothing is emitted; the scan restarts at col 0.
- Width/arithmetic: tick, debounce and release counters are sized with clog2 of their limits. The code is {row[1:0], col[1:0]}.

Test Plan:
Use SCAN_DIV=4, DEBOUNCE_CNT=2, and ready held at 1 unless stated.
- Reset/idle: reset low for 3 cycles then high, no keys → col_o=1110 after reset; column rotates 1110→1101→1011→0111→1110 every 4 cycles; valid never asserts; word_o=0.
- Single press: hold row 2 low only while col 1 is driven, for ≥3 ticks, then release → exactly one valid pulse with code 4'h9; word_o=32'h00000009; the column rotates again only after 2 clean release ticks.
- Bounce rejection: row 0 low for 1 tick at col 3, then high → no valid; FSM back to SCAN; col_o advances to 1110.
- Handshake backpressure: ready=0, press keys 3 then 5 → valid held with code 3; overflow_o=1; word_o=32'h00000035; raising ready for 1 cycle drops valid.
- Entry and clear: press 1,2,…,9 in sequence → word_o=32'h23456789; then pulse clear_i → word_o=0 and overflow_o=0.
- Async reset mid-DEBOUNCE (after 1 matching tick) → outputs return to reset values immediately, with no emission after release.
